// File: rtl/full_adder_resp_checker_pkg.sv
// rtl/full_adder_resp_checker_pkg.sv - shared types and widths for the full adder response checker
package fa_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int COV_W     = 8;
    localparam int ERR_VEC_W = 5;

endpackage

// File: rtl/full_adder_resp_checker_if.sv
// rtl/full_adder_resp_checker_if.sv - vector/response bus and result signals of the checker
interface full_adder_resp_checker_if #(
    parameter int CNT_W = 16
) ();
    import fa_chk_pkg::*;

    logic                 start;
    logic                 valid_i;
    logic                 a_i;
    logic                 b_i;
    logic                 c_i_1;
    logic                 s_i;
    logic                 c_i;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CNT_W-1:0]     vec_cnt;
    logic [CNT_W-1:0]     err_cnt;
    logic [COV_W-1:0]     cov_map;
    logic [CNT_W-1:0]     first_err_idx;
    logic [ERR_VEC_W-1:0] first_err_vec;

    modport master (
        output start, valid_i, a_i, b_i, c_i_1, s_i, c_i,
        input  busy, done, pass, vec_cnt, err_cnt, cov_map, first_err_idx, first_err_vec
    );

    modport slave (
        input  start, valid_i, a_i, b_i, c_i_1, s_i, c_i,
        output busy, done, pass, vec_cnt, err_cnt, cov_map, first_err_idx, first_err_vec
    );

endinterface

// File: rtl/full_adder_resp_checker_ref_model.sv
// rtl/full_adder_resp_checker_ref_model.sv - combinational golden 1-bit full adder
module fa_ref_model (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_cin;
    assign o_c = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/full_adder_resp_checker.sv
// rtl/full_adder_resp_checker.sv - full adder response checker top; FA_CHK_STOP_ON_ERR_EN ends a run at the first mismatch
module full_adder_resp_checker
    import fa_chk_pkg::*;
#(
    parameter int NUM_VECTORS = 400,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    full_adder_resp_checker_if.slave    bus
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_vec_cnt;
    logic [CNT_W-1:0]     r_err_cnt;
    logic [CNT_W-1:0]     r_first_err_idx;
    logic [COV_W-1:0]     r_cov_map;
    logic [ERR_VEC_W-1:0] r_first_err_vec;
    logic                 r_pass;

    logic                 w_exp_s;
    logic                 w_exp_c;
    logic                 w_mismatch;
    logic                 w_clear;
    logic                 w_check;
    logic                 w_last;
    logic [2:0]           w_idx;
    logic [COV_W-1:0]     w_cov_nxt;
    logic [CNT_W-1:0]     w_err_nxt;

    fa_ref_model u_ref (
        .i_a   (bus.a_i),
        .i_b   (bus.b_i),
        .i_cin (bus.c_i_1),
        .o_s   (w_exp_s),
        .o_c   (w_exp_c)
    );

    assign w_idx      = {bus.a_i, bus.b_i, bus.c_i_1};
    assign w_mismatch = (bus.s_i != w_exp_s) || (bus.c_i != w_exp_c);
    assign w_last     = (r_vec_cnt == CNT_W'(NUM_VECTORS - 1));
    assign w_cov_nxt  = r_cov_map | (COV_W'(1) << w_idx);
    assign w_err_nxt  = (w_mismatch && !(&r_err_cnt)) ? r_err_cnt + CNT_W'(1) : r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_check     = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                // A start sample is never checked, even with valid_i high.
                if (bus.start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (bus.valid_i) begin
                    w_check = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
`ifdef FA_CHK_STOP_ON_ERR_EN
                    if (w_mismatch) begin
                        w_state_nxt = DONE;
                    end
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            r_vec_cnt       <= '0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_cov_map       <= '0;
            r_first_err_vec <= '0;
            r_pass          <= 1'b0;
        end else if (w_check) begin
            r_vec_cnt <= r_vec_cnt + CNT_W'(1);
            r_cov_map <= w_cov_nxt;
            r_err_cnt <= w_err_nxt;
            if (w_mismatch && (r_err_cnt == '0)) begin
                r_first_err_idx <= r_vec_cnt;
                r_first_err_vec <= {w_idx, bus.s_i, bus.c_i};
            end
            // Verdict uses the post-update counts so a failing last vector is included.
            if (w_state_nxt == DONE) begin
                r_pass <= (w_err_nxt == '0) && (&w_cov_nxt);
            end
        end
    end

    assign bus.busy          = (r_state == CHECK);
    assign bus.done          = (r_state == DONE);
    assign bus.pass          = r_pass;
    assign bus.vec_cnt       = r_vec_cnt;
    assign bus.err_cnt       = r_err_cnt;
    assign bus.cov_map       = r_cov_map;
    assign bus.first_err_idx = r_first_err_idx;
    assign bus.first_err_vec = r_first_err_vec;

endmodule

// File: tb/tb_full_adder_resp_checker.sv
// tb/tb_full_adder_resp_checker.sv - randomized self-checking bench for full_adder_resp_checker
module tb_full_adder_resp_checker;

    localparam int N  = 400;
    localparam int CW = 16;
`ifdef FA_CHK_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    full_adder_resp_checker_if #(.CNT_W(CW)) bus ();

    full_adder_resp_checker #(.NUM_VECTORS(N), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: 0 = idle, 1 = running, 2 = finished.
    int            m_state;
    logic [CW-1:0] m_vec, m_err, m_fidx;
    logic [7:0]    m_cov;
    logic [4:0]    m_fvec;
    logic          m_pass;

    function automatic logic [1:0] fa_sum(input bit a, input bit b, input bit c);
        int t;
        t = int'(a) + int'(b) + int'(c);
        return t[1:0];
    endfunction

    function automatic logic [63:0] dut_pack();
        return {bus.busy, bus.done, bus.pass, bus.vec_cnt, bus.err_cnt,
                bus.cov_map, bus.first_err_idx, bus.first_err_vec};
    endfunction

    function automatic logic [63:0] model_pack();
        return {m_state == 1, m_state == 2, m_pass, m_vec, m_err, m_cov, m_fidx, m_fvec};
    endfunction

    task automatic model_clear();
        m_vec = '0; m_err = '0; m_fidx = '0; m_cov = '0; m_fvec = '0; m_pass = 1'b0;
    endtask

    task automatic step(input bit st, input bit v, input bit a, input bit b, input bit c,
                        input bit s, input bit co);
        bit mis;
        bus.start = st; bus.valid_i = v;
        bus.a_i = a; bus.b_i = b; bus.c_i_1 = c; bus.s_i = s; bus.c_i = co;
        @(posedge clk);
        mis = ({co, s} != fa_sum(a, b, c));
        if (!rst_n) begin
            model_clear();
            m_state = 0;
        end else if (m_state != 1) begin
            if (st) begin
                model_clear();
                m_state = 1;
            end
        end else if (v) begin
            if (mis) begin
                if (m_err == 0) begin
                    m_fidx = m_vec;
                    m_fvec = {a, b, c, s, co};
                end
                if (m_err != '1) m_err = m_err + 1;
            end
            m_vec = m_vec + 1;
            m_cov[{a, b, c}] = 1'b1;
            if (m_vec == N || (STOP && mis)) begin
                m_state = 2;
                m_pass  = (m_err == 0) && (m_cov == 8'hFF);
            end
        end
        #1;
        bus.start = 1'b0; bus.valid_i = 1'b0;
    endtask

    // fault: 0 = correct response, 1 = carry-out stuck at 0, 2 = sum inverted
    task automatic drive_vec(input bit st, input bit v, input logic [2:0] abc, input int fault);
        logic [1:0] r;
        bit s, co;
        r  = fa_sum(abc[2], abc[1], abc[0]);
        s  = r[0];
        co = r[1];
        if (fault == 1) co = 1'b0;
        if (fault == 2) s = ~s;
        step(st, v, abc[2], abc[1], abc[0], s, co);
    endtask

    function automatic logic [2:0] rnd3();
        return 3'($urandom_range(0, 7));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive_vec(1'b0, 1'b0, 3'b000, 0);
        drive_vec(1'b1, 1'b1, 3'b111, 2);
        rst_n = 1'b1;
        drive_vec(1'b0, 1'b0, 3'b000, 0);
        checks++;
        if (dut_pack() !== model_pack() || dut_pack() !== 64'h0) begin
            fails++; $display("FAIL reset: got %h expected %h", dut_pack(), model_pack());
        end
        drive_vec(1'b0, 1'b1, 3'b111, 2);
        checks++;
        if (dut_pack() !== model_pack()) begin
            fails++; $display("FAIL idle_valid_ignored: got %h expected %h", dut_pack(), model_pack());
        end
    endtask

    task automatic test_exhaustive();
        drive_vec(1'b1, 1'b0, 3'b000, 0);
        checks++;
        if (dut_pack() !== model_pack() || bus.busy !== 1'b1) begin
            fails++; $display("FAIL start_busy: got %h expected %h", dut_pack(), model_pack());
        end
        for (int i = 0; i < N; i++) drive_vec(1'b0, 1'b1, (i < 8) ? 3'(i) : rnd3(), 0);
        checks++;
        if (dut_pack() !== model_pack()) begin
            fails++; $display("FAIL exhaustive_final: got %h expected %h", dut_pack(), model_pack());
        end
        checks++;
        if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.vec_cnt !== CW'(N) || bus.cov_map !== 8'hFF) begin
            fails++; $display("FAIL exhaustive_pass: done=%b pass=%b vec=%0d cov=%h required 1 1 %0d ff",
                              bus.done, bus.pass, bus.vec_cnt, bus.cov_map, N);
        end
        drive_vec(1'b0, 1'b1, 3'b100, 2);
        checks++;
        if (dut_pack() !== model_pack()) begin
            fails++; $display("FAIL done_valid_ignored: got %h expected %h", dut_pack(), model_pack());
        end
    endtask

    task automatic test_carry_stuck();
        drive_vec(1'b1, 1'b0, 3'b000, 0);
        checks++;
        if (dut_pack() !== model_pack() || bus.done !== 1'b0) begin
            fails++; $display("FAIL restart_clears: got %h expected %h", dut_pack(), model_pack());
        end
        drive_vec(1'b0, 1'b1, 3'b000, 1);
        drive_vec(1'b0, 1'b1, 3'b100, 1);
        drive_vec(1'b0, 1'b1, 3'b110, 1);
        for (int i = 3; i < N; i++) drive_vec(1'b0, 1'b1, rnd3(), 1);
        checks++;
        if (bus.first_err_idx !== CW'(2) || bus.first_err_vec !== 5'b11000) begin
            fails++; $display("FAIL carry_first_err: got idx=%0d vec=%b required idx=2 vec=11000",
                              bus.first_err_idx, bus.first_err_vec);
        end
        checks++;
        if (bus.pass !== 1'b0 || bus.err_cnt === '0 || bus.done !== 1'b1) begin
            fails++; $display("FAIL carry_verdict: got pass=%b err=%0d done=%b required pass=0 err>=1 done=1",
                              bus.pass, bus.err_cnt, bus.done);
        end
        checks++;
        if (dut_pack() !== model_pack()) begin
            fails++; $display("FAIL carry_final: got %h expected %h", dut_pack(), model_pack());
        end
    endtask

    task automatic test_a_only();
        drive_vec(1'b1, 1'b0, 3'b000, 0);
        for (int i = 0; i < N; i++) drive_vec(1'b0, 1'b1, {i[0], 2'b00}, 0);
        checks++;
        if (bus.cov_map !== 8'b00010001 || bus.err_cnt !== '0 || bus.pass !== 1'b0) begin
            fails++; $display("FAIL a_only_cov: got cov=%b err=%0d pass=%b required cov=00010001 err=0 pass=0",
                              bus.cov_map, bus.err_cnt, bus.pass);
        end
        checks++;
        if (dut_pack() !== model_pack()) begin
            fails++; $display("FAIL a_only_final: got %h expected %h", dut_pack(), model_pack());
        end
    endtask

    task automatic test_valid_gaps();
        int k;
        bit v;
        drive_vec(1'b1, 1'b0, 3'b000, 0);
        k = 0;
        while (k < 4 * N && bus.done !== 1'b1) begin
            k++;
            v = (k % 2 == 0);
            // Gap cycles carry wrong responses and a stray start that must be ignored.
            drive_vec(k == 3, v, rnd3(), v ? 0 : 2);
        end
        checks++;
        if (bus.done !== 1'b1 || k !== 2 * N) begin
            fails++; $display("FAIL gaps_done_timing: got done=%b after %0d cycles required done=1 after %0d",
                              bus.done, k, 2 * N);
        end
        checks++;
        if (dut_pack() !== model_pack()) begin
            fails++; $display("FAIL gaps_final: got %h expected %h", dut_pack(), model_pack());
        end
    endtask

    task automatic test_reset_mid_run();
        drive_vec(1'b1, 1'b0, 3'b000, 0);
        for (int i = 0; i < 5; i++) drive_vec(1'b0, 1'b1, rnd3(), 1);
        rst_n = 1'b0;
        drive_vec(1'b0, 1'b1, 3'b110, 1);
        rst_n = 1'b1;
        checks++;
        if (dut_pack() !== model_pack() || dut_pack() !== 64'h0) begin
            fails++; $display("FAIL mid_reset: got %h expected %h", dut_pack(), model_pack());
        end
        drive_vec(1'b1, 1'b0, 3'b000, 0);
        for (int i = 0; i < N; i++) drive_vec(1'b0, 1'b1, 3'(i), 0);
        checks++;
        if (dut_pack() !== model_pack() || bus.pass !== 1'b1) begin
            fails++; $display("FAIL after_reset_run: got %h expected %h", dut_pack(), model_pack());
        end
    endtask

    task automatic test_start_valid_and_last_err();
        rst_n = 1'b0;
        drive_vec(1'b0, 1'b0, 3'b000, 0);
        rst_n = 1'b1;
        drive_vec(1'b1, 1'b1, 3'b111, 2);
        checks++;
        if (dut_pack() !== model_pack() || bus.vec_cnt !== '0 || bus.err_cnt !== '0) begin
            fails++; $display("FAIL start_valid_same_cycle: got %h expected %h", dut_pack(), model_pack());
        end
        for (int i = 0; i < N - 1; i++) drive_vec(1'b0, 1'b1, 3'(i), 0);
        drive_vec(1'b0, 1'b1, rnd3(), 2);
        checks++;
        if (bus.err_cnt !== CW'(1) || bus.pass !== 1'b0 || bus.first_err_idx !== CW'(N - 1)) begin
            fails++; $display("FAIL last_mismatch: got err=%0d pass=%b idx=%0d required err=1 pass=0 idx=%0d",
                              bus.err_cnt, bus.pass, bus.first_err_idx, N - 1);
        end
        checks++;
        if (dut_pack() !== model_pack()) begin
            fails++; $display("FAIL last_final: got %h expected %h", dut_pack(), model_pack());
        end
    endtask

    task automatic test_stop_on_err();
        drive_vec(1'b1, 1'b0, 3'b000, 0);
        drive_vec(1'b0, 1'b1, 3'b000, 2);
        checks++;
        if (bus.done !== STOP || bus.vec_cnt !== CW'(1) || bus.err_cnt !== CW'(1)) begin
            fails++; $display("FAIL stop_first_valid: got done=%b vec=%0d err=%0d required done=%b vec=1 err=1",
                              bus.done, bus.vec_cnt, bus.err_cnt, STOP);
        end
        for (int i = 1; i < N; i++) drive_vec(1'b0, 1'b1, 3'(i), 0);
        checks++;
        if (bus.vec_cnt !== (STOP ? CW'(1) : CW'(N)) || bus.pass !== 1'b0 || bus.err_cnt !== CW'(1)) begin
            fails++; $display("FAIL stop_final_counts: got vec=%0d pass=%b err=%0d required vec=%0d pass=0 err=1",
                              bus.vec_cnt, bus.pass, bus.err_cnt, STOP ? 1 : N);
        end
        checks++;
        if (dut_pack() !== model_pack()) begin
            fails++; $display("FAIL stop_final: got %h expected %h", dut_pack(), model_pack());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.valid_i = 1'b0;
        bus.a_i = 1'b0; bus.b_i = 1'b0; bus.c_i_1 = 1'b0; bus.s_i = 1'b0; bus.c_i = 1'b0;
        m_state = 0;
        model_clear();
        test_reset();
        test_exhaustive();
        test_carry_stuck();
        test_a_only();
        test_valid_gaps();
        test_reset_mid_run();
        test_start_valid_and_last_err();
        test_stop_on_err();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
